// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    S_RUN,
    S_RMW
  } state_e;

  // Requester ids, also the encoding of the last-grant pointer.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_M = 1'b1;

  function automatic logic is_partial(input logic [1:0] sz);
    return (sz == SZ_HALF) || (sz == SZ_BYTE);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
module rr_arbiter2
  import regfile_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       last_q
);

  logic last_d;

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt[REQ_A] = 1'b1;
        2'b10:   gnt[REQ_M] = 1'b1;
        2'b11: begin
          if (last_q == REQ_M) gnt[REQ_A] = 1'b1;
          else                 gnt[REQ_M] = 1'b1;
        end
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (upd && (gnt != '0)) last_d = gnt[REQ_M] ? REQ_M : REQ_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_M;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and load writeback;
// sub-word loads merge into the old register value via a read-modify-write.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  input  logic [1:0]        m_size,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic [ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [1:0]        pend_size_q, pend_size_d;

  logic [1:0]        gnt;
  logic              arb_en;
  logic              hs;
  logic              last_grant;
  logic [DATA_W-1:0] merged;

  // Readys are forced low while reset is held, not just after the first edge.
  assign arb_en = rst_n && (state_q == S_RUN);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({m_valid, a_valid}),
    .en     (arb_en),
    .upd    (hs),
    .gnt    (gnt),
    .last_q (last_grant)
  );

  assign a_ready = gnt[REQ_A];
  assign m_ready = gnt[REQ_M];
  assign hs      = (a_valid && a_ready) || (m_valid && m_ready);

  always_comb begin
    merged = rf_rd_data;
    if (pend_size_q == SZ_HALF) merged = {rf_rd_data[DATA_W-1:16], pend_data_q[15:0]};
    else                        merged = {rf_rd_data[DATA_W-1:8],  pend_data_q[7:0]};
  end

  always_comb begin
    state_d      = state_q;
    rf_we_d      = 1'b0;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;
    rf_rd_addr_d = rf_rd_addr_q;
    busy_d       = 1'b0;
    pend_data_d  = pend_data_q;
    pend_size_d  = pend_size_q;
    unique case (state_q)
      S_RUN: begin
        if (a_valid && a_ready) begin
          rf_we_d = (a_addr != '0);
          rf_wa_d = a_addr;
          rf_wd_d = a_data;
        end else if (m_valid && m_ready) begin
          if (is_partial(m_size)) begin
            rf_rd_addr_d = m_addr;
            pend_data_d  = m_data;
            pend_size_d  = m_size;
            busy_d       = 1'b1;
            state_d      = S_RMW;
          end else begin
            rf_we_d = (m_addr != '0);
            rf_wa_d = m_addr;
            rf_wd_d = m_data;
          end
        end
      end
      S_RMW: begin
        // rf_rd_addr_q doubles as the latched destination of the pending load.
        rf_we_d = (rf_rd_addr_q != '0);
        rf_wa_d = rf_rd_addr_q;
        rf_wd_d = merged;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
      rf_rd_addr_q <= '0;
      busy_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_size_q  <= SZ_WORD;
    end else begin
      state_q      <= state_d;
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      busy_q       <= busy_d;
      pend_data_q  <= pend_data_d;
      pend_size_q  <= pend_size_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_wa      = rf_wa_q;
  assign rf_wd      = rf_wd_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, m_valid, m_ready;
  logic [4:0]  a_addr, m_addr, rf_rd_addr, rf_wa;
  logic [31:0] a_data, m_data, rf_rd_data, rf_wd;
  logic [1:0]  m_size;
  logic        rf_we, busy;
  logic        model_init;
  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
    .m_data     (m_data),
    .m_size     (m_size),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .busy       (busy)
  );

  // Register file model: not tied to DUT reset so mid-RMW reset keeps contents.
  always @(posedge clk) begin
    if (!model_init) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && rf_wa != 5'd0) begin
      regs[rf_wa] <= rf_wd;
    end
  end
  assign rf_rd_data = regs[rf_rd_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; model_init = 1'b0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = '0;
    m_valid = 1'b1; m_addr = 5'd2; m_data = '0; m_size = 2'b00;
    repeat (2) @(posedge clk);
    #1 model_init = 1'b1;
    check_eq("rst_a_ready", 32'(a_ready), 32'd0);
    check_eq("rst_m_ready", 32'(m_ready), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_rf_wa", 32'(rf_wa), 32'd0);
    check_eq("rst_rf_wd", rf_wd, 32'd0);
    check_eq("rst_rd_addr", 32'(rf_rd_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    a_valid = 1'b0; m_valid = 1'b0;
    #2 rst_n = 1'b1;

    // Single ALU word write
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1234_5678; #1;
    check_eq("w_a_ready", 32'(a_ready), 32'd1);
    check_eq("w_m_ready", 32'(m_ready), 32'd0);
    step(); a_valid = 1'b0; #1;
    check_eq("w_rf_we", 32'(rf_we), 32'd1);
    check_eq("w_rf_wa", 32'(rf_wa), 32'd3);
    check_eq("w_rf_wd", rf_wd, 32'h1234_5678);

    // Preload reg9 via A, then reg5 via M (size 00), leaving pointer at M
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1111_2222;
    step(); a_valid = 1'b0;
    m_valid = 1'b1; m_addr = 5'd5; m_data = 32'hDEAD_BEEF; m_size = 2'b00; #1;
    check_eq("pre_m_ready", 32'(m_ready), 32'd1);
    step(); m_valid = 1'b0; #1;
    check_eq("pre_rf_wa", 32'(rf_wa), 32'd5);

    // Tie: alternating grants A, M, A, M
    a_valid = 1'b1; a_addr = 5'd1; m_valid = 1'b1; m_addr = 5'd2; m_size = 2'b00;
    for (int i = 0; i < 4; i++) begin
      a_data = 32'hA000_0000 + i; m_data = 32'hB000_0000 + i; #1;
      check_eq($sformatf("tie%0d_a_ready", i), 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("tie%0d_m_ready", i), 32'(m_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check_eq($sformatf("tie%0d_rf_we", i), 32'(rf_we), 32'd1);
      check_eq($sformatf("tie%0d_rf_wa", i), 32'(rf_wa), (i % 2 == 0) ? 32'd1 : 32'd2);
      check_eq($sformatf("tie%0d_rf_wd", i), rf_wd,
               (i % 2 == 0) ? 32'hA000_0000 + i : 32'hB000_0000 + i);
    end
    a_valid = 1'b0; m_valid = 1'b0;
    step();
    check_eq("idle_rf_we", 32'(rf_we), 32'd0);
    check_eq("idle_rf_wa_hold", 32'(rf_wa), 32'd2);
    check_eq("idle_rf_wd_hold", rf_wd, 32'hB000_0003);

    // Byte RMW to reg5 (old 0xDEADBEEF); A word write to r0 queued behind it
    m_valid = 1'b1; m_addr = 5'd5; m_data = 32'h0000_00AB; m_size = 2'b10; #1;
    check_eq("b_m_ready", 32'(m_ready), 32'd1);
    step(); m_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF; #1;
    check_eq("b_busy", 32'(busy), 32'd1);
    check_eq("b_rd_addr", 32'(rf_rd_addr), 32'd5);
    check_eq("b_a_ready", 32'(a_ready), 32'd0);
    check_eq("b_m_ready_rmw", 32'(m_ready), 32'd0);
    check_eq("b_rf_we_rmw", 32'(rf_we), 32'd0);
    step();
    check_eq("b_rf_we", 32'(rf_we), 32'd1);
    check_eq("b_rf_wa", 32'(rf_wa), 32'd5);
    check_eq("b_rf_wd", rf_wd, 32'hDEAD_BEAB);
    check_eq("b_busy_done", 32'(busy), 32'd0);
    check_eq("z_a_ready", 32'(a_ready), 32'd1);
    step(); a_valid = 1'b0; #1;
    check_eq("z_rf_we", 32'(rf_we), 32'd0);

    // Half RMW to reg9 (old 0x11112222)
    m_valid = 1'b1; m_addr = 5'd9; m_data = 32'h0000_CAFE; m_size = 2'b01; #1;
    check_eq("h_m_ready", 32'(m_ready), 32'd1);
    step(); m_valid = 1'b0; #1;
    check_eq("h_busy", 32'(busy), 32'd1);
    step();
    check_eq("h_rf_we", 32'(rf_we), 32'd1);
    check_eq("h_rf_wa", 32'(rf_wa), 32'd9);
    check_eq("h_rf_wd", rf_wd, 32'h1111_CAFE);

    // RAW: word write to reg7 then byte RMW to reg7 next cycle
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h5566_7788; #1;
    check_eq("raw_a_ready", 32'(a_ready), 32'd1);
    step(); a_valid = 1'b0;
    m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h0000_00EE; m_size = 2'b10; #1;
    check_eq("raw_rf_we1", 32'(rf_we), 32'd1);
    check_eq("raw_m_ready", 32'(m_ready), 32'd1);
    step(); m_valid = 1'b0; #1;
    check_eq("raw_rd_addr", 32'(rf_rd_addr), 32'd7);
    check_eq("raw_rd_data", rf_rd_data, 32'h5566_7788);
    step();
    check_eq("raw_rf_wa", 32'(rf_wa), 32'd7);
    check_eq("raw_rf_wd", rf_wd, 32'h5566_77EE);

    // Size 11 is a plain word write
    m_valid = 1'b1; m_addr = 5'd4; m_data = 32'hCAFE_BABE; m_size = 2'b11; #1;
    step(); m_valid = 1'b0; #1;
    check_eq("s11_rf_we", 32'(rf_we), 32'd1);
    check_eq("s11_rf_wd", rf_wd, 32'hCAFE_BABE);
    check_eq("s11_busy", 32'(busy), 32'd0);

    // Reset asserted mid-RMW
    m_valid = 1'b1; m_addr = 5'd5; m_data = 32'h0000_0011; m_size = 2'b10; #1;
    step(); m_valid = 1'b0; #1;
    check_eq("r_busy_pre", 32'(busy), 32'd1);
    #1 rst_n = 1'b0; #1;
    check_eq("r_busy_async", 32'(busy), 32'd0);
    check_eq("r_rf_we_async", 32'(rf_we), 32'd0);
    check_eq("r_rd_addr_async", 32'(rf_rd_addr), 32'd0);
    step(); step();
    #1 rst_n = 1'b1;
    step();
    check_eq("r_no_write", 32'(rf_we), 32'd0);
    check_eq("r_reg5_kept", regs[5], 32'hDEAD_BEAB);
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h0000_000A;
    m_valid = 1'b1; m_addr = 5'd11; m_data = 32'h0000_000B; m_size = 2'b00; #1;
    check_eq("r_tie_a_ready", 32'(a_ready), 32'd1);
    check_eq("r_tie_m_ready", 32'(m_ready), 32'd0);
    step(); a_valid = 1'b0; m_valid = 1'b0; #1;
    check_eq("r_tie_rf_wa", 32'(rf_wa), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
